// File: rtl/dsp_ctrl_pkg.sv
// rtl/dsp_ctrl_pkg.sv - OPMODE field constants, composed opmodes, FSM states and tag type
package dsp_ctrl_pkg;

  // X mux select, OPMODE[1:0]
  localparam logic [1:0] X_ZERO = 2'b00;
  localparam logic [1:0] X_M    = 2'b01;

  // Z mux select, OPMODE[3:2]
  localparam logic [1:0] Z_ZERO = 2'b00;
  localparam logic [1:0] Z_P    = 2'b10;
  localparam logic [1:0] Z_C    = 2'b11;

  // Pre-adder, carry-in, pre-subtract and post-subtract are never used
  localparam logic [3:0] OPM_HI = 4'b0000;

  localparam logic [7:0] OPM_OFF       = 8'h00;
  localparam logic [7:0] OPM_FIRST     = {OPM_HI, Z_ZERO, X_M};  // P = M
  localparam logic [7:0] OPM_ACC       = {OPM_HI, Z_P,    X_M};  // P = P + M
  localparam logic [7:0] OPM_HOLD      = {OPM_HI, Z_P,    X_ZERO}; // P = P
  localparam logic [7:0] OPM_FIRST_RND = {OPM_HI, Z_C,    X_M};  // P = M + C

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// rtl/dsp_mac_sequencer_if.sv - command, sample, result and DSP-slice signal bundle
interface dsp_mac_sequencer_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             s_valid;
  logic             s_ready;
  logic [17:0]      s_a;
  logic [17:0]      s_b;
  logic             m_valid;
  logic             m_ready;
  logic [47:0]      m_result;
  logic [17:0]      dsp_A;
  logic [17:0]      dsp_B;
  logic [17:0]      dsp_D;
  logic [47:0]      dsp_C;
  logic [7:0]       dsp_OPMODE;
  logic             dsp_CE;
  logic             dsp_RST;
  logic [47:0]      dsp_P;

  // Sequencer side
  modport master (
    input  cmd_valid, cmd_len, s_valid, s_a, s_b, m_ready, dsp_P,
    output cmd_ready, s_ready, m_valid, m_result,
    output dsp_A, dsp_B, dsp_D, dsp_C, dsp_OPMODE, dsp_CE, dsp_RST
  );

  // Upstream logic plus DSP slice side
  modport slave (
    output cmd_valid, cmd_len, s_valid, s_a, s_b, m_ready, dsp_P,
    input  cmd_ready, s_ready, m_valid, m_result,
    input  dsp_A, dsp_B, dsp_D, dsp_C, dsp_OPMODE, dsp_CE, dsp_RST
  );
endinterface

// File: rtl/dsp_tag_pipe.sv
// rtl/dsp_tag_pipe.sv - fixed-depth shift register delaying {valid, first, last} sample tags
module dsp_tag_pipe
  import dsp_ctrl_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t stage_q [DEPTH];

  // Shift tags one stage per cycle; reset empties the pipe so no stale opmode survives an abort
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - streaming MAC controller for one DSP slice; DSP_MAC_ROUND_EN adds ROUND_C
module dsp_mac_sequencer
  import dsp_ctrl_pkg::*;
#(
  parameter int          LEN_W     = 8,
  parameter int          OPM_ALIGN = 1,
  parameter int          RES_LAT   = 3,
  parameter logic [47:0] ROUND_C   = 48'h0
) (
  input logic clk,
  input logic RST,
  dsp_mac_sequencer_if.master bus
);

`ifdef DSP_MAC_ROUND_EN
  localparam bit RND_EN = 1'b1;
`else
  localparam bit RND_EN = 1'b0;
`endif

  localparam logic [7:0]  OPM_FIRST_SEL = RND_EN ? OPM_FIRST_RND : OPM_FIRST;
  localparam logic [47:0] C_VAL         = RND_EN ? ROUND_C : 48'h0;
  // Cycles to wait after the last tag leaves the pipe so capture lands RES_LAT+2 edges after the last handshake
  localparam int DRAIN_WAIT = RES_LAT + 1 - OPM_ALIGN;
  localparam int CNT_W      = $clog2(DRAIN_WAIT + 2);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             first_q, first_d;
  logic [17:0]      a_q, a_d, b_q, b_d;
  logic [7:0]       opm_q, opm_d;
  logic [47:0]      c_q;
  logic [47:0]      res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  tag_t             tag_in, tag_out;

  dsp_tag_pipe #(.DEPTH(OPM_ALIGN)) u_tag_pipe (
    .clk_i (clk),
    .rst_i (RST),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus job bookkeeping: sample capture, remaining count, drain timer, result capture
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    first_d = first_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    tag_in  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_len == '0) begin
            state_d = ST_DONE;
            res_d   = C_VAL;
          end else begin
            state_d = ST_ACC;
            rem_d   = bus.cmd_len;
            first_d = 1'b1;
          end
        end
      end
      ST_ACC: begin
        if (bus.s_valid) begin
          a_d          = bus.s_a;
          b_d          = bus.s_b;
          rem_d        = rem_q - LEN_W'(1);
          first_d      = 1'b0;
          tag_in.valid = 1'b1;
          tag_in.first = first_q;
          tag_in.last  = (rem_q == LEN_W'(1));
          if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (tag_out.valid && tag_out.last) begin
          armed_d = 1'b1;
          cnt_d   = CNT_W'(DRAIN_WAIT);
        end else if (armed_q) begin
          if (cnt_q == '0) begin
            res_d   = bus.dsp_P;
            armed_d = 1'b0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (bus.m_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // OPMODE follows the delayed tag while a job runs; the slice is idle (all zero) otherwise
  always_comb begin
    opm_d = OPM_OFF;
    if (state_q == ST_ACC || state_q == ST_DRAIN) begin
      if (tag_out.valid) opm_d = tag_out.first ? OPM_FIRST_SEL : OPM_ACC;
      else               opm_d = OPM_HOLD;
    end
  end

  // Datapath and control registers
  always_ff @(posedge clk) begin
    if (RST) begin
      rem_q   <= '0;
      first_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      opm_q   <= OPM_OFF;
      c_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      first_q <= first_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opm_q   <= opm_d;
      c_q     <= C_VAL;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign bus.cmd_ready  = (state_q == ST_IDLE);
  assign bus.s_ready    = (state_q == ST_ACC);
  assign bus.m_valid    = (state_q == ST_DONE);
  assign bus.m_result   = res_q;
  assign bus.dsp_A      = a_q;
  assign bus.dsp_B      = b_q;
  assign bus.dsp_D      = '0;
  assign bus.dsp_C      = c_q;
  assign bus.dsp_OPMODE = opm_q;
  assign bus.dsp_CE     = 1'b1;
  // Slice registers clear on the same edge as the sequencer
  assign bus.dsp_RST    = RST;

endmodule
